// File: rtl/de_issue_queue_pkg.sv
// Shared types and helpers for the decode/issue queue and its register scoreboard.
package de_issue_queue_pkg;
  localparam int SB_W_DEF = 2;
  localparam int REG_AW   = 5;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } iq_entry_t;

  // MIPS register fields, shared by the decoder and anything that needs them
  function automatic logic [4:0] get_rs(input logic [31:0] i);
    return i[25:21];
  endfunction
  function automatic logic [4:0] get_rt(input logic [31:0] i);
    return i[20:16];
  endfunction
  function automatic logic [4:0] get_rd(input logic [31:0] i);
    return i[15:11];
  endfunction
endpackage

// File: rtl/de_scoreboard.sv
// Per-register count of issued-but-unretired writers; register 0 is never tracked.
module de_scoreboard
  import de_issue_queue_pkg::*;
#(
  parameter int NREG = 32,
  parameter int SB_W = SB_W_DEF
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc_en,
  input  logic [REG_AW-1:0] inc_addr,
  input  logic              dec_en,
  input  logic [REG_AW-1:0] dec_addr,
  input  logic [REG_AW-1:0] rd0_addr,
  input  logic [REG_AW-1:0] rd1_addr,
  input  logic [REG_AW-1:0] rd2_addr,
  output logic [SB_W-1:0]   rd0_cnt,
  output logic [SB_W-1:0]   rd1_cnt,
  output logic [SB_W-1:0]   rd2_cnt
);
  logic [NREG-1:0][SB_W-1:0] cnt;
  logic [NREG-1:0]           underflow;

  assign cnt[0]       = '0;
  assign underflow[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    logic            inc, dec;
    logic [SB_W-1:0] cnt_q, cnt_d;
    always_comb begin
      inc   = inc_en && (inc_addr == REG_AW'(r));
      dec   = dec_en && (dec_addr == REG_AW'(r));
      cnt_d = cnt_q;
      if (clr)                           cnt_d = '0;
      else if (inc && !dec)              cnt_d = cnt_q + SB_W'(1);
      else if (dec && !inc && cnt_q != '0) cnt_d = cnt_q - SB_W'(1);
    end
    always_ff @(posedge clk or posedge rst)
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    assign cnt[r]       = cnt_q;
    assign underflow[r] = dec && !inc && !clr && (cnt_q == '0);
  end

  assign rd0_cnt = cnt[rd0_addr];
  assign rd1_cnt = cnt[rd1_addr];
  assign rd2_cnt = cnt[rd2_addr];

  // a retire with no writer in flight means the pipeline lost track of a register
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) underflow == '0);
endmodule

// File: rtl/de_issue_queue.sv
// Decode/issue FIFO between IF and EX: scoreboard interlock, delay-slot tracking, redirect squash.
module de_issue_queue
  import de_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NREG  = 32,
  parameter int SB_W  = SB_W_DEF
)(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [31:0]                enq_pc,
  input  logic [31:0]                enq_instr,
  input  logic                       enq_exc,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [31:0]                deq_pc,
  output logic [31:0]                deq_instr,
  output logic                       deq_exc,
  output logic                       deq_bd,
  input  logic [4:0]                 hd_rs,
  input  logic                       hd_rs_r,
  input  logic [4:0]                 hd_rt,
  input  logic                       hd_rt_r,
  input  logic [4:0]                 hd_dst,
  input  logic                       hd_dst_w,
  input  logic                       hd_br,
  input  logic                       wb_valid,
  input  logic [4:0]                 wb_addr,
  input  logic                       redirect,
  input  logic                       flush,
  output logic                       hazard,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [SB_W-1:0] SB_MAX = '1;

  iq_entry_t [DEPTH-1:0] ent_q, ent_d;
  iq_entry_t             head;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_next;
  logic [CW-1:0] count_q, count_d, remain;
  logic          last_br_q, last_br_d, ds_issued_q, ds_issued_d, ds_wait_q, ds_wait_d;
  logic          empty, full, head_exc, deq_fire, enq_fire, ds_now, sb_inc;
  logic [SB_W-1:0] sb_rs, sb_rt, sb_dst;

  de_scoreboard #(.NREG(NREG), .SB_W(SB_W)) u_sb (
    .clk(clk), .rst(reset), .clr(flush),
    .inc_en(sb_inc), .inc_addr(hd_dst),
    .dec_en(wb_valid && wb_addr != '0), .dec_addr(wb_addr),
    .rd0_addr(hd_rs), .rd1_addr(hd_rt), .rd2_addr(hd_dst),
    .rd0_cnt(sb_rs), .rd1_cnt(sb_rt), .rd2_cnt(sb_dst)
  );

  always_comb begin
    head     = ent_q[rd_ptr_q];
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    head_exc = !empty && head.exc;
    hazard   = !empty && !head_exc &&
               ((hd_rs_r  && hd_rs  != '0 && sb_rs  != '0) ||
                (hd_rt_r  && hd_rt  != '0 && sb_rt  != '0) ||
                (hd_dst_w && hd_dst != '0 && sb_dst == SB_MAX));
    deq_valid = !empty && !hazard && !flush;
    deq_fire  = deq_valid && deq_ready;
    // redirect is judged after this cycle's issue: a delay slot leaving now counts as issued
    ds_now    = ds_issued_q || (deq_fire && last_br_q);
    remain    = count_q - CW'(deq_fire);
    enq_ready = redirect ? (!flush && !ds_now && remain == '0) : (!flush && !full);
    enq_fire  = enq_valid && enq_ready;
    sb_inc    = deq_fire && !head_exc && hd_dst_w && hd_dst != '0;
  end

  assign deq_pc    = empty ? '0 : head.pc;
  assign deq_instr = empty ? '0 : head.instr;
  assign deq_exc   = head_exc;
  assign deq_bd    = last_br_q;
  assign count     = count_q;

  always_comb begin
    ent_d = ent_q;
    if (enq_fire) ent_d[wr_ptr_q] = '{pc: enq_pc, instr: enq_instr, exc: enq_exc};
    rd_next     = rd_ptr_q + PW'(deq_fire);
    rd_ptr_d    = rd_next;
    wr_ptr_d    = wr_ptr_q + PW'(enq_fire);
    count_d     = remain + CW'(enq_fire);
    last_br_d   = last_br_q;
    ds_issued_d = ds_issued_q;
    ds_wait_d   = ds_wait_q && !enq_fire;
    if (deq_fire) begin
      last_br_d = hd_br;
      if (hd_br)          ds_issued_d = 1'b0;
      else if (last_br_q) ds_issued_d = 1'b1;
    end
    if (redirect) begin
      if (ds_now) begin
        wr_ptr_d = rd_next;
        count_d  = '0;
      end else if (remain != '0) begin
        wr_ptr_d = rd_next + PW'(1);
        count_d  = CW'(1);
      end else if (!enq_fire) begin
        ds_wait_d = 1'b1;
      end
    end
    if (flush) begin
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
      last_br_d   = 1'b0;
      ds_issued_d = 1'b0;
      ds_wait_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_q       <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      last_br_q   <= 1'b0;
      ds_issued_q <= 1'b0;
      ds_wait_q   <= 1'b0;
    end else begin
      ent_q       <= ent_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      last_br_q   <= last_br_d;
      ds_issued_q <= ds_issued_d;
      ds_wait_q   <= ds_wait_d;
    end
  end
endmodule

// File: doc/de_issue_queue.md
Name: de_issue_queue

Overview:
- Parametrised decode/issue front end for the MIPS pipeline. Sits between IF and EX.
- Holds up to DEPTH fetched instructions in a FIFO.
- Replaces per-stage forwarding comparators with a per-register pending-write scoreboard, so the number of in-flight writers is unlimited by stage count.
- Tracks branch delay slots and squashes wrong-path entries on a taken-branch redirect from EX.
- A companion combinational decoder supplies the head instruction's register usage.

Parameters:
- DEPTH, 4, queue entries (power of 2, ≥2)
- NREG, 32, architectural registers tracked; index 0 never tracked
- SB_W, 2, scoreboard counter width; max in-flight writers per register = 2^SB_W−1

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- enq_valid  in  1  fetch offers an instruction
- enq_ready  out  1  queue accepts (not full, not squashing)
- enq_pc  in  32  fetch PC
- enq_instr  in  32  instruction word
- enq_exc  in  1  fetch-side exception attached
- deq_valid  out  1  head may issue this cycle
- deq_ready  in  1  EX accepts
- deq_pc  out  32  head PC
- deq_instr  out  32  head instruction
- deq_exc  out  1  head carries a fetch exception
- deq_bd  out  1  head is a branch delay slot
- hd_rs  in  5  head rs (from decoder)
- hd_rs_r  in  1  head reads rs
- hd_rt  in  5  head rt
- hd_rt_r  in  1  head reads rt
- hd_dst  in  5  head destination register
- hd_dst_w  in  1  head writes hd_dst
- hd_br  in  1  head is a branch or jump
- wb_valid  in  1  a register write retires
- wb_addr  in  5  retiring destination
- redirect  in  1  EX: branch issued last fire was taken
- flush  in  1  exception/ERET flush
- hazard  out  1  head blocked by scoreboard
- count  out  $clog2(DEPTH+1)  occupancy

Behaviour:
- **Reset** (async, high): queue empty, count=0, all scoreboard counters 0, last_br=0, ds_issued=0, ds_wait=0. Outputs: deq_valid=0, enq_ready=1, hazard=0, deq_bd=0, deq_* data 0.
- **FIFO:** registered; an enqueue appears at deq_* the next cycle at the earliest (no bypass).
  - enq fire = enq_valid && enq_ready.
  - enq_ready = !full && !flush && !redirect. Exception: during redirect, enq_ready=1 when the delay-slot rule below keeps the incoming word.
  - When full, a simultaneous deq fire does not open a slot in the same cycle.
- **Hazard:** hazard = !empty && !deq_exc && any of:
  - hd_rs_r && hd_rs≠0 && sb[hd_rs]≠0
  - hd_rt_r && hd_rt≠0 && sb[hd_rt]≠0
  - hd_dst_w && hd_dst≠0 && sb[hd_dst]==max
- **Issue:** deq_valid = !empty && !hazard && !flush; deq fire = deq_valid && deq_ready. Exception entries (deq_exc=1) ignore the scoreboard and never increment it.
- **Scoreboard:**
  - On deq fire with hd_dst_w && hd_dst≠0: sb[hd_dst]+1.
  - On wb_valid && wb_addr≠0: sb[wb_addr]−1.
  - Both on the same register in the same cycle: unchanged.
  - A decrement at 0 is a protocol error; the counter holds at 0 and an assertion fires.
- **Delay slot:**
  - On deq fire, last_br <= hd_br.
  - deq_bd = last_br.
  - ds_issued is set by any deq fire while last_br=1 and cleared by the next branch fire.
- **Redirect** (cycle after branch issue), evaluated after the same-cycle deq:
  - ds_issued=1: discard all entries and the incoming enq.
  - ds_issued=0, queue non-empty: keep the head only (the delay slot); discard the rest and the incoming enq.
  - ds_issued=0, queue empty: accept the incoming enq as the delay slot if present; otherwise set ds_wait. ds_wait accepts exactly the next enq, then clears.
  - Fetch redirects itself and never presents wrong-path words after the delay slot.
- **Flush:** highest priority. Empties the queue, zeroes all scoreboard counters, clears last_br, ds_issued and ds_wait. No deq fire and no enq in the flush cycle. Pipeline guarantees killed instructions never assert wb_valid afterwards.
- **Pointers:** wrap modulo DEPTH; count is exact.

Decomposition:
- common.vh additions: EXC code constants (already present), SB_W default, and a GET_RS/GET_RT/GET_RD field-macro reuse.
- One sub-module, de_scoreboard: NREG×SB_W counters with inc/dec ports and three read ports. Queue storage stays inline.

Test Plan:
- Enqueue 4 independent ADDU ($1..$4 ← $0) with deq_ready=1 → issue on consecutive cycles starting one cycle after the first enq; count peaks at 1; hazard never set.
- ADDU $5 issued, then head reads $5 → hazard=1 and deq_valid=0 until the cycle after wb_valid with wb_addr=5; then it issues; sb[5] returns 0.
- Three writers of $7 in flight (SB_W=2) → fourth writer of $7 stalls with hazard=1; one wb_valid for $7 releases it.
- Branch issues; queue holds {ds, w1, w2}; redirect → ds issues with deq_bd=1; w1/w2 never issue; count=0 afterwards.
- Branch issues with queue empty; redirect → ds_wait set; next enq issues with deq_bd=1; ds_wait clears.
- Queue full (count=4) with pending sb[9]=2; assert flush → count=0, all sb=0, enq_ready=1 the next cycle; reset mid-issue → all outputs at reset values immediately.
